ctl_seq: RTL and testbench
==========================

CTL_SEQ -- requirements
Module: ctl_seq

Interface
REQ-001 SHALL have parameter DW, default 36, microcode word width (>= AW+FW+4).
REQ-002 SHALL have parameter AW, default 9, microcode address width (>= 9).
REQ-003 SHALL have parameter FW, default 5, finisher index width (<= AW-2).
REQ-004 SHALL have parameter SD, default 2, micro-call stack depth (1..8).
REQ-005 SHALL have parameters RST_VEC 'h160, IRQ_VEC 'h168, NMI_VEC 'h170, FIN_BASE 'h140 (AW-bit addresses).
REQ-006 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports rdy in 1 (0 = stall), DB in 8 (opcode bus), cond in 1 (branch condition), irq in 1 (level), nmi in 1 (edge), I in 1 (IRQ mask).
REQ-009 SHALL have port ucode_addr  out  AW  combinational address to external 1-cycle synchronous-read ROM.
REQ-010 SHALL have port ucode_data  in  DW  ROM word for the address presented on the previous edge.
REQ-011 SHALL have ports ctrl out DW (word, forced 0 when not started), sync out 1, WE out 1 (registered), finish out FW.
REQ-012 SHALL have ports int_ack out 1, int_src out 2 (01 IRQ, 10 NMI), err_ovf out 1, err_unf out 1.

Function
REQ-013 Fields: seq = ucode_data[DW-1:DW-3]; nxt = ucode_data[AW-2:0]; fin = ucode_data[AW+FW-2:AW-1]; we_n = ucode_data[DW-4].
REQ-014 Register pc_q SHALL capture ucode_addr every edge; "started" SHALL set on the first edge after reset release.
REQ-015 While started=0: ucode_addr = RST_VEC, sync=0, ctrl=0, no state update except started.
REQ-016 While rdy=0 (started=1): ucode_addr = pc_q; finish, stack, WE, error flags hold; nmi edge detection continues.
REQ-017 seq 000 DECODE: sync=1; next = NMI_VEC if NMI pending, else IRQ_VEC if irq&~I, else {0,DB} zero-extended.
REQ-018 seq 001 JUMP: next = {1,nxt}.
REQ-019 seq 010 FINISH: next = FIN_BASE | finish.
REQ-020 seq 011 JUMP_SAVE: next = {1,nxt}; finish <= fin.
REQ-021 seq 100 CALL: push pc_q+1 (mod 2^AW); next = {1,nxt}.
REQ-022 seq 101 RET: pop; next = popped address.
REQ-023 seq 110 BRANCH: next = cond ? {1,nxt} : pc_q+1.
REQ-024 seq 111 WAIT: next = pc_q until NMI pending or irq=1 (regardless of I); then behave as DECODE.
REQ-025 sync SHALL be 1 only when started, rdy=1 and seq=000 (or WAIT resolving).
REQ-026 WE SHALL register we_n each non-stalled edge; WE=0 while not started.
REQ-027 NMI pending SHALL set on a rising edge of nmi (registered compare) and clear when NMI taken; a new edge in the take cycle SHALL leave it set.
REQ-028 int_ack SHALL pulse one cycle (registered) after an interrupt vector is issued, with int_src valid that cycle, 00 otherwise.
REQ-029 CALL with stack full SHALL still jump, drop the push, set sticky err_ovf.
REQ-030 RET with stack empty SHALL jump to RST_VEC and set sticky err_unf.
REQ-031 Stack depth count SHALL never exceed SD or go below 0.

Reset
REQ-032 Reset SHALL asynchronously clear started, WE, finish, stack count, NMI pending, nmi history, int_ack, int_src, err_ovf, err_unf; pc_q = RST_VEC.
REQ-033 Reset asserted mid-instruction SHALL abort it; after release the first word executed SHALL be the RST_VEC word.

Verification
REQ-034 Reset release, ROM[160]=JUMP nxt 05 -> ucode_addr 160, then 105; sync 0 throughout.
REQ-035 DECODE, DB=A9, irq=1, I=1 -> ucode_addr 0A9, sync=1; same with I=0 -> 168, int_ack next cycle, int_src=01.
REQ-036 nmi 0->1 during multi-cycle sequence, irq=1, I=0 -> next DECODE issues 170 (not 168); int_src=10; pending cleared.
REQ-037 SD=2: CALL at 110,120,130 -> stack {111,121}, err_ovf=1; RET,RET,RET -> 121, 111, 160 with err_unf=1.
REQ-038 rdy=0 for 3 cycles during JUMP_SAVE fin=0x03 -> ucode_addr, WE, ctrl frozen; after release finish=03, FINISH issues 143.
REQ-039 BRANCH at 12F, nxt 40: cond=1 -> 140; cond=0 -> 130; WAIT with irq=1, I=1 -> leaves WAIT, DECODE path issues opcode address.

Source files
------------

// File: rtl/ctl_seq.sv
// Microcode control sequencer: picks the next ROM address from the current word's seq field.
// Latency: ucode_addr is combinational; ctrl is the ROM word one edge after its address; WE/int_ack are registered one cycle later.
// Backpressure: rdy=0 re-presents pc_q and freezes finish, stack, WE and error flags; nmi edge detection keeps running.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   rdy, DB, cond       stall (0), opcode bus, branch condition
//   irq, nmi, I         level IRQ, edge NMI, IRQ mask
//   ucode_addr/_data    address to / word from a 1-cycle synchronous ROM
//   ctrl, sync, WE      control word, opcode-fetch strobe, registered write enable
//   finish              saved finisher index
//   int_ack, int_src    one-cycle acknowledge after a vector is issued (01 IRQ, 10 NMI)
//   err_ovf, err_unf    sticky micro-call stack overflow / underflow
module ctl_seq #(
  parameter int DW = 36,
  parameter int AW = 9,
  parameter int FW = 5,
  parameter int SD = 2,
  parameter logic [AW-1:0] RST_VEC  = 'h160,
  parameter logic [AW-1:0] IRQ_VEC  = 'h168,
  parameter logic [AW-1:0] NMI_VEC  = 'h170,
  parameter logic [AW-1:0] FIN_BASE = 'h140
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rdy,
  input  logic [7:0]    DB,
  input  logic          cond,
  input  logic          irq,
  input  logic          nmi,
  input  logic          I,
  output logic [AW-1:0] ucode_addr,
  input  logic [DW-1:0] ucode_data,
  output logic [DW-1:0] ctrl,
  output logic          sync,
  output logic          WE,
  output logic [FW-1:0] finish,
  output logic          int_ack,
  output logic [1:0]    int_src,
  output logic          err_ovf,
  output logic          err_unf
);

  localparam int CW = $clog2(SD + 1);

  localparam logic [2:0] SEQ_DECODE = 3'b000;
  localparam logic [2:0] SEQ_JUMP   = 3'b001;
  localparam logic [2:0] SEQ_FINISH = 3'b010;
  localparam logic [2:0] SEQ_JSAVE  = 3'b011;
  localparam logic [2:0] SEQ_CALL   = 3'b100;
  localparam logic [2:0] SEQ_RET    = 3'b101;
  localparam logic [2:0] SEQ_BRANCH = 3'b110;
  localparam logic [2:0] SEQ_WAIT   = 3'b111;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            pc_q;
  logic [SD-1:0][AW-1:0]    stk_q;   // stk_q[0] is top of stack
  logic [CW-1:0]            cnt_q;
  logic                     nmi_q, nmi_pend_q;

  // Microcode word fields
  logic [2:0]    seq;
  logic [AW-2:0] nxt;
  logic [FW-1:0] fin;
  logic          we_n;

  assign seq  = ucode_data[DW-1:DW-3];
  assign nxt  = ucode_data[AW-2:0];
  assign fin  = ucode_data[AW+FW-2:AW-1];
  assign we_n = ucode_data[DW-4];

  logic [AW-1:0] jmp_addr, pc_inc, db_addr, fin_addr;
  assign jmp_addr = {1'b1, nxt};
  assign pc_inc   = pc_q + AW'(1);
  assign db_addr  = {{(AW-8){1'b0}}, DB};
  assign fin_addr = FIN_BASE | {{(AW-FW){1'b0}}, finish};

  logic running;
  assign running = (state_q == ST_RUN);
  assign ctrl    = running ? ucode_data : '0;

  logic decode, take_nmi, take_irq, do_push, do_pop, load_fin, ovf_set, unf_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = ST_RUN;   // leaves idle on the first edge after reset release
    ucode_addr = RST_VEC;
    sync       = 1'b0;
    decode     = 1'b0;
    take_nmi   = 1'b0;
    take_irq   = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    load_fin   = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (!running) begin
      ucode_addr = RST_VEC;
    end else if (!rdy) begin
      ucode_addr = pc_q;   // re-read the same word so ucode_data stays put
    end else begin
      case (seq)
        SEQ_DECODE: decode = 1'b1;
        SEQ_JUMP:   ucode_addr = jmp_addr;
        SEQ_FINISH: ucode_addr = fin_addr;
        SEQ_JSAVE: begin
          ucode_addr = jmp_addr;
          load_fin   = 1'b1;
        end
        SEQ_CALL: begin
          ucode_addr = jmp_addr;
          if (cnt_q == CW'(SD)) ovf_set = 1'b1;
          else                  do_push = 1'b1;
        end
        SEQ_RET: begin
          if (cnt_q == '0) begin
            ucode_addr = RST_VEC;
            unf_set    = 1'b1;
          end else begin
            ucode_addr = stk_q[0];
            do_pop     = 1'b1;
          end
        end
        SEQ_BRANCH: ucode_addr = cond ? jmp_addr : pc_inc;
        default: begin
          // WAIT wakes on any pending NMI or raw irq, even when masked
          if (nmi_pend_q || irq) decode = 1'b1;
          else                   ucode_addr = pc_q;
        end
      endcase
      if (decode) begin
        sync = 1'b1;
        if (nmi_pend_q) begin
          ucode_addr = NMI_VEC;
          take_nmi   = 1'b1;
        end else if (irq && !I) begin
          ucode_addr = IRQ_VEC;
          take_irq   = 1'b1;
        end else begin
          ucode_addr = db_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RST_VEC;
      WE         <= 1'b0;
      finish     <= '0;
      stk_q      <= '0;
      cnt_q      <= '0;
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
      int_ack    <= 1'b0;
      int_src    <= 2'b00;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
    end else begin
      pc_q <= ucode_addr;
      if (running) begin
        nmi_q <= nmi;
        // a fresh edge in the take cycle wins over the clear
        nmi_pend_q <= (nmi & ~nmi_q) | (nmi_pend_q & ~take_nmi);
        int_ack    <= take_nmi | take_irq;
        int_src    <= {take_nmi, take_irq};
        if (rdy) begin
          WE <= we_n;
          if (load_fin) finish <= fin;
          if (ovf_set)  err_ovf <= 1'b1;
          if (unf_set)  err_unf <= 1'b1;
          if (do_push) begin
            for (int k = SD - 1; k > 0; k--) stk_q[k] <= stk_q[k-1];
            stk_q[0] <= pc_inc;
            cnt_q    <= cnt_q + CW'(1);
          end else if (do_pop) begin
            for (int k = 0; k < SD - 1; k++) stk_q[k] <= stk_q[k+1];
            cnt_q <= cnt_q - CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ctl_seq.sv
// Directed bench for ctl_seq: a microcode ROM program walked by a table of per-cycle vectors,
// followed by hand-written reset-abort and NMI re-arm sequences.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_ctl_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        rdy;
  logic [7:0]  db;
  logic        cond, irq, nmi, i_mask;
  logic [8:0]  ucode_addr;
  logic [35:0] ucode_data;
  logic [35:0] ctrl;
  logic        sync, we;
  logic [4:0]  finish;
  logic        int_ack;
  logic [1:0]  int_src;
  logic        err_ovf, err_unf;

  int checks = 0;
  int errors = 0;

  logic [35:0] rom [0:511];

  always #5 clk = ~clk;

  always @(posedge clk) ucode_data <= rom[ucode_addr];

  ctl_seq dut (
    .clk(clk), .reset(reset), .rdy(rdy), .DB(db), .cond(cond), .irq(irq),
    .nmi(nmi), .I(i_mask), .ucode_addr(ucode_addr), .ucode_data(ucode_data),
    .ctrl(ctrl), .sync(sync), .WE(we), .finish(finish), .int_ack(int_ack),
    .int_src(int_src), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  function automatic logic [35:0] mk(input logic [2:0] s, input logic w,
                                     input logic [4:0] f, input logic [7:0] n);
    return {s, w, 19'b0, f, n};
  endfunction

  typedef struct packed {
    logic       rdy;
    logic [7:0] db;
    logic       cond, irq, nmi, imask;
    logic [8:0] addr;
    logic       sync, we, ack;
    logic [1:0] src;
    logic       ovf, unf;
    logic [4:0] fin;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [7:0] d, input logic c,
                             input logic q, input logic n, input logic m,
                             input logic [8:0] a, input logic sy, input logic w,
                             input logic ak, input logic [1:0] sr, input logic ov,
                             input logic un, input logic [4:0] f);
    vec_t t;
    t.rdy = r; t.db = d; t.cond = c; t.irq = q; t.nmi = n; t.imask = m;
    t.addr = a; t.sync = sy; t.we = w; t.ack = ak; t.src = sr;
    t.ovf = ov; t.unf = un; t.fin = f;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] d, input logic c,
                       input logic q, input logic n, input logic m);
    rdy = r; db = d; cond = c; irq = q; nmi = n; i_mask = m;
  endtask

  vec_t        tbl [0:36];
  logic [35:0] w168;

  initial begin
    for (int a = 0; a < 512; a++) rom[a] = '0;
    rom[9'h160] = mk(3'b001, 1'b1, 5'h00, 8'h05);  // JUMP 105
    rom[9'h105] = mk(3'b000, 1'b0, 5'h00, 8'h00);  // DECODE
    rom[9'h0A9] = mk(3'b001, 1'b1, 5'h00, 8'h05);  // JUMP 105
    rom[9'h168] = mk(3'b011, 1'b1, 5'h03, 8'h10);  // JUMP_SAVE 110, fin 3
    rom[9'h110] = mk(3'b100, 1'b1, 5'h00, 8'h20);  // CALL 120
    rom[9'h120] = mk(3'b100, 1'b0, 5'h00, 8'h30);  // CALL 130
    rom[9'h130] = mk(3'b100, 1'b1, 5'h00, 8'h40);  // CALL 140
    rom[9'h140] = mk(3'b101, 1'b0, 5'h00, 8'h00);  // RET
    rom[9'h121] = mk(3'b101, 1'b1, 5'h00, 8'h00);  // RET
    rom[9'h111] = mk(3'b101, 1'b0, 5'h00, 8'h00);  // RET
    rom[9'h02F] = mk(3'b010, 1'b1, 5'h00, 8'h00);  // FINISH
    rom[9'h143] = mk(3'b001, 1'b0, 5'h00, 8'h2F);  // JUMP 12F
    rom[9'h12F] = mk(3'b110, 1'b1, 5'h00, 8'h40);  // BRANCH 140
    rom[9'h131] = mk(3'b111, 1'b0, 5'h00, 8'h00);  // WAIT
    rom[9'h055] = mk(3'b001, 1'b1, 5'h00, 8'h80);  // JUMP 180
    rom[9'h180] = mk(3'b001, 1'b0, 5'h00, 8'h81);  // JUMP 181
    rom[9'h181] = mk(3'b001, 1'b1, 5'h00, 8'h82);  // JUMP 182
    rom[9'h182] = mk(3'b000, 1'b0, 5'h00, 8'h00);  // DECODE
    rom[9'h170] = mk(3'b001, 1'b1, 5'h00, 8'h05);  // JUMP 105
    w168 = mk(3'b011, 1'b1, 5'h03, 8'h10);

    //            rdy db    c  q  n  m   addr    sy we ak src   ov un fin
    tbl[0]  = v(1, 8'h00, 0, 0, 0, 1, 9'h160, 0, 0, 0, 2'd0, 0, 0, 5'd0);
    tbl[1]  = v(1, 8'h00, 0, 0, 0, 1, 9'h105, 0, 0, 0, 2'd0, 0, 0, 5'd0);
    tbl[2]  = v(1, 8'hA9, 0, 1, 0, 1, 9'h0A9, 1, 1, 0, 2'd0, 0, 0, 5'd0);
    tbl[3]  = v(1, 8'h00, 0, 0, 0, 1, 9'h105, 0, 0, 0, 2'd0, 0, 0, 5'd0);
    tbl[4]  = v(1, 8'hA9, 0, 1, 0, 0, 9'h168, 1, 1, 0, 2'd0, 0, 0, 5'd0);
    tbl[5]  = v(0, 8'h00, 0, 0, 0, 1, 9'h168, 0, 0, 1, 2'd1, 0, 0, 5'd0);
    tbl[6]  = v(0, 8'h00, 0, 0, 0, 1, 9'h168, 0, 0, 0, 2'd0, 0, 0, 5'd0);
    tbl[7]  = v(0, 8'h00, 0, 0, 0, 1, 9'h168, 0, 0, 0, 2'd0, 0, 0, 5'd0);
    tbl[8]  = v(1, 8'h00, 0, 0, 0, 1, 9'h110, 0, 0, 0, 2'd0, 0, 0, 5'd0);
    tbl[9]  = v(1, 8'h00, 0, 0, 0, 1, 9'h120, 0, 1, 0, 2'd0, 0, 0, 5'd3);
    tbl[10] = v(1, 8'h00, 0, 0, 0, 1, 9'h130, 0, 1, 0, 2'd0, 0, 0, 5'd3);
    tbl[11] = v(1, 8'h00, 0, 0, 0, 1, 9'h140, 0, 0, 0, 2'd0, 0, 0, 5'd3);
    tbl[12] = v(1, 8'h00, 0, 0, 0, 1, 9'h121, 0, 1, 0, 2'd0, 1, 0, 5'd3);
    tbl[13] = v(1, 8'h00, 0, 0, 0, 1, 9'h111, 0, 0, 0, 2'd0, 1, 0, 5'd3);
    tbl[14] = v(1, 8'h00, 0, 0, 0, 1, 9'h160, 0, 1, 0, 2'd0, 1, 0, 5'd3);
    tbl[15] = v(1, 8'h00, 0, 0, 0, 1, 9'h105, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[16] = v(1, 8'h2F, 0, 0, 0, 1, 9'h02F, 1, 1, 0, 2'd0, 1, 1, 5'd3);
    tbl[17] = v(1, 8'h00, 0, 0, 0, 1, 9'h143, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[18] = v(1, 8'h00, 0, 0, 0, 1, 9'h12F, 0, 1, 0, 2'd0, 1, 1, 5'd3);
    tbl[19] = v(1, 8'h00, 1, 0, 0, 1, 9'h140, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[20] = v(1, 8'h00, 0, 0, 0, 1, 9'h160, 0, 1, 0, 2'd0, 1, 1, 5'd3);
    tbl[21] = v(1, 8'h00, 0, 0, 0, 1, 9'h105, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[22] = v(1, 8'h2F, 0, 0, 0, 1, 9'h02F, 1, 1, 0, 2'd0, 1, 1, 5'd3);
    tbl[23] = v(1, 8'h00, 0, 0, 0, 1, 9'h143, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[24] = v(1, 8'h00, 0, 0, 0, 1, 9'h12F, 0, 1, 0, 2'd0, 1, 1, 5'd3);
    tbl[25] = v(1, 8'h00, 0, 0, 0, 1, 9'h130, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[26] = v(1, 8'h00, 0, 0, 0, 1, 9'h140, 0, 1, 0, 2'd0, 1, 1, 5'd3);
    tbl[27] = v(1, 8'h00, 0, 0, 0, 1, 9'h131, 0, 1, 0, 2'd0, 1, 1, 5'd3);
    tbl[28] = v(1, 8'h55, 0, 0, 0, 1, 9'h131, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[29] = v(1, 8'h55, 0, 0, 0, 1, 9'h131, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[30] = v(1, 8'h55, 0, 1, 0, 1, 9'h055, 1, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[31] = v(1, 8'h00, 0, 0, 0, 1, 9'h180, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[32] = v(1, 8'h00, 0, 0, 1, 1, 9'h181, 0, 1, 0, 2'd0, 1, 1, 5'd3);
    tbl[33] = v(1, 8'h00, 0, 0, 1, 1, 9'h182, 0, 0, 0, 2'd0, 1, 1, 5'd3);
    tbl[34] = v(1, 8'h55, 0, 1, 1, 0, 9'h170, 1, 1, 0, 2'd0, 1, 1, 5'd3);
    tbl[35] = v(1, 8'h00, 0, 0, 1, 1, 9'h105, 0, 0, 1, 2'd2, 1, 1, 5'd3);
    tbl[36] = v(1, 8'h3C, 0, 0, 1, 1, 9'h03C, 1, 1, 0, 2'd0, 1, 1, 5'd3);

    reset = 1'b1;
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 37; k++) begin
      drive(tbl[k].rdy, tbl[k].db, tbl[k].cond, tbl[k].irq, tbl[k].nmi, tbl[k].imask);
      #1;
      chk($sformatf("r%0d addr", k),    36'(ucode_addr), 36'(tbl[k].addr));
      chk($sformatf("r%0d sync", k),    36'(sync),       36'(tbl[k].sync));
      chk($sformatf("r%0d we", k),      36'(we),         36'(tbl[k].we));
      chk($sformatf("r%0d int_ack", k), 36'(int_ack),    36'(tbl[k].ack));
      chk($sformatf("r%0d int_src", k), 36'(int_src),    36'(tbl[k].src));
      chk($sformatf("r%0d err_ovf", k), 36'(err_ovf),    36'(tbl[k].ovf));
      chk($sformatf("r%0d err_unf", k), 36'(err_unf),    36'(tbl[k].unf));
      chk($sformatf("r%0d finish", k),  36'(finish),     36'(tbl[k].fin));
      if (k == 0)      chk("r0 ctrl idle", ctrl, 36'h0);
      if (!tbl[k].rdy) chk($sformatf("r%0d ctrl frozen", k), ctrl, w168);
      @(negedge clk);
    end

    // Reset in the middle of a cycle aborts the running word immediately
    #2 reset = 1'b1;
    #1;
    chk("rst addr",    36'(ucode_addr), 36'h160);
    chk("rst ctrl",    ctrl,            36'h0);
    chk("rst sync",    36'(sync),       36'h0);
    chk("rst we",      36'(we),         36'h0);
    chk("rst finish",  36'(finish),     36'h0);
    chk("rst int_ack", 36'(int_ack),    36'h0);
    chk("rst err_ovf", 36'(err_ovf),    36'h0);
    chk("rst err_unf", 36'(err_unf),    36'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 8'hA9, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("h0 addr", 36'(ucode_addr), 36'h160);
    chk("h0 sync", 36'(sync), 36'h0);
    @(negedge clk);
    nmi = 1'b1;                       // edge while running JUMP at 160
    #1 chk("h1 addr", 36'(ucode_addr), 36'h105);
    @(negedge clk);
    rdy = 1'b0; nmi = 1'b0;           // stall at DECODE, nmi falls
    #1 chk("h2 addr", 36'(ucode_addr), 36'h105);
    chk("h2 sync", 36'(sync), 36'h0);
    @(negedge clk);
    rdy = 1'b1; nmi = 1'b1;           // new edge in the take cycle
    #1 chk("h3 addr", 36'(ucode_addr), 36'h170);
    chk("h3 sync", 36'(sync), 36'h1);
    @(negedge clk);
    #1 chk("h4 addr", 36'(ucode_addr), 36'h105);
    chk("h4 int_ack", 36'(int_ack), 36'h1);
    chk("h4 int_src", 36'(int_src), 36'h2);
    @(negedge clk);
    #1 chk("h5 nmi rearmed", 36'(ucode_addr), 36'h170);
    @(negedge clk);
    #1 chk("h6 addr", 36'(ucode_addr), 36'h105);
    @(negedge clk);
    #1 chk("h7 nmi cleared", 36'(ucode_addr), 36'h0A9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
